sdrc_port_arb: RTL and testbench
================================

// Module: sdrc_port_arb
// PURPOSE
//  Multi-port request arbiter in front of the sdrc_core application interface.
//  Shares one SDRAM controller between NP requesters (e.g. wb2sdrc plus DMA
//  engines) and allows one transfer outstanding at a time.
//  Steers write-next and read-valid strobes back to the owning port.
//  Sits between the bus bridges and sdrc_core in sdrc_top.
// PARAMETERS
//  NP     4   number of requester ports (2..8)
//  APP_AW 26  application address width
//  dw     32  application data width
//  bl     9   burst length field width
// PORTS
//  sdram_clk       in   1          controller clock
//  sdram_resetn    in   1          asynchronous active-low reset
//  p_req           in   NP         per-port request, held until p_req_ack
//  p_req_addr      in   NP*APP_AW  per-port address, port i at [i*APP_AW +: APP_AW]
//  p_req_len       in   NP*bl      per-port burst length (words)
//  p_req_wr_n      in   NP         0 = write, 1 = read
//  p_req_ack       out  NP         1-cycle acceptance pulse to the granted port
//  p_wr_data       in   NP*dw      per-port write data
//  p_wr_en_n       in   NP*dw/8    per-port byte enables, active low
//  p_wr_next       out  NP         write-beat strobe to the owning port
//  p_rd_valid      out  NP         read-beat strobe to the owning port
//  p_last_rd       out  NP         last read beat to the owning port
//  p_rd_data       out  dw         read data, broadcast to all ports
//  grant_id        out  3          index of the current owner
//  arb_busy        out  1          high from grant until transfer completion
//  app_req         out  1          to sdrc_core; also drives app_req_dma_last
//  app_req_addr    out  APP_AW     to sdrc_core
//  app_req_len     out  bl         to sdrc_core
//  app_req_wr_n    out  1          to sdrc_core
//  app_req_ack     in   1          from sdrc_core
//  app_wr_data     out  dw         muxed write data
//  app_wr_en_n     out  dw/8       muxed byte enables; all 1s when idle
//  app_wr_next_req in   1          from sdrc_core
//  app_rd_valid    in   1          from sdrc_core
//  app_last_rd     in   1          from sdrc_core
//  app_rd_data     in   dw         from sdrc_core
// BEHAVIOUR
//  Reset values: app_req=0, addr/len=0, wr_n=1, app_wr_en_n all 1s,
//   p_* strobes=0, grant_id=0, arb_busy=0, FSM=IDLE, RR pointer=0.
//  FSM states: IDLE, REQ, WDATA, RDATA.
//  IDLE
//   - With any p_req set, grant the first requesting port at or after the RR
//     pointer, wrapping from NP-1 to 0.
//   - Register the granted port's addr, len and wr_n; set app_req=1 next cycle.
//   - Set arb_busy=1 on the same edge. Decision to app_req latency: 1 clk.
//  REQ
//   - Hold app_req and all request fields stable until app_req_ack.
//   - On ack: pulse p_req_ack[grant] for 1 clk; drop app_req on the same edge.
//   - Move RR pointer to grant+1 mod NP.
//   - len==0: go to IDLE. Otherwise go to WDATA (wr_n=0) or RDATA (wr_n=1).
//  WDATA
//   - app_wr_data and app_wr_en_n combinationally follow the owner's port.
//   - p_wr_next[grant] = app_wr_next_req, combinational and zero-latency.
//   - Beat counter loads len and decrements on each app_wr_next_req.
//   - Go to IDLE on the cycle the counter goes 1 to 0.
//  RDATA
//   - p_rd_valid[grant]=app_rd_valid and p_last_rd[grant]=app_last_rd,
//     combinational.
//   - Go to IDLE on app_rd_valid & app_last_rd.
//  Leaving a data state clears arb_busy. A new grant may be made in the
//   following IDLE cycle.
//  Outside WDATA/RDATA, stray strobes from sdrc_core are ignored: no p_*
//   strobe is asserted.
//  Requests arriving in any state other than IDLE wait; they are never lost.
//  Simultaneous requests resolve by RR order only.
//  Async reset mid-transfer returns everything to reset values immediately.
//   No ack or strobe is issued after reset.
// CONFIGURATION
//  SDRC_ARB_FIXED_PRIO_EN
//   - Defined: port 0 always wins when requesting. Ports 1..NP-1 round-robin
//     among themselves with the same pointer rules.
//   - Undefined: pure round-robin across all NP ports.
// TESTING
//  1. Reset, then p_req[2] read of len=4, addr=0x100.
//     -> app_req 1 clk later with addr 0x100, len 4, wr_n 1;
//        p_req_ack[2] on app_req_ack;
//        4 p_rd_valid[2] pulses; p_last_rd[2] on the 4th; arb_busy falls.
//  2. Ports 0,1,3 all request at once, each a 1-word write; pointer=0.
//     -> grants in order 0,1,3; each p_wr_next goes only to its owner;
//        app_wr_data equals the owner's data.
//  3. p_req[1] with len=0.
//     -> ack pulse, no data phase, FSM back to IDLE in 1 clk.
//  4. Assert sdram_resetn low mid-WDATA after 2 of 8 beats.
//     -> outputs at reset values; no further p_wr_next;
//        a fresh request is served normally after reset.
//  5. Apply app_rd_valid while idle.
//     -> no p_rd_valid asserted on any port.
//  6. With SDRC_ARB_FIXED_PRIO_EN defined, ports 0 and 2 request continuously.
//     -> port 0 wins every arbitration; without the macro the grants alternate
//        0,2,0,2.

Source files
------------

// File: rtl/sdrc_port_arb.sv
// Multi-port round-robin arbiter in front of the sdrc_core application interface.
// Define SDRC_ARB_FIXED_PRIO_EN to give port 0 absolute priority over ports 1..NP-1.
module sdrc_port_arb #(
    parameter int NP     = 4,
    parameter int APP_AW = 26,
    parameter int dw     = 32,
    parameter int bl     = 9
) (
    input  logic                 sdram_clk,
    input  logic                 sdram_resetn,
    input  logic [NP-1:0]        p_req,
    input  logic [NP*APP_AW-1:0] p_req_addr,
    input  logic [NP*bl-1:0]     p_req_len,
    input  logic [NP-1:0]        p_req_wr_n,
    output logic [NP-1:0]        p_req_ack,
    input  logic [NP*dw-1:0]     p_wr_data,
    input  logic [NP*dw/8-1:0]   p_wr_en_n,
    output logic [NP-1:0]        p_wr_next,
    output logic [NP-1:0]        p_rd_valid,
    output logic [NP-1:0]        p_last_rd,
    output logic [dw-1:0]        p_rd_data,
    output logic [2:0]           grant_id,
    output logic                 arb_busy,
    output logic                 app_req,
    output logic [APP_AW-1:0]    app_req_addr,
    output logic [bl-1:0]        app_req_len,
    output logic                 app_req_wr_n,
    input  logic                 app_req_ack,
    output logic [dw-1:0]        app_wr_data,
    output logic [dw/8-1:0]      app_wr_en_n,
    input  logic                 app_wr_next_req,
    input  logic                 app_rd_valid,
    input  logic                 app_last_rd,
    input  logic [dw-1:0]        app_rd_data
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] WDATA = 2'd2;
    localparam logic [1:0] RDATA = 2'd3;

    logic [1:0]        state;
    logic [2:0]        rr_ptr;
    logic [2:0]        grant;
    logic [bl-1:0]     beat_cnt;

    logic [NP-1:0]     req_eff;
    logic [NP-1:0]     rr_req;
    logic [2:0]        lo_pick;
    logic [2:0]        hi_pick;
    logic              hi_found;
    logic [2:0]        pick;
    logic [NP-1:0]     grant_oh;
    logic [APP_AW-1:0] sel_addr;
    logic [bl-1:0]     sel_len;
    logic              sel_wr_n;
    logic [2:0]        next_ptr;

    assign grant_id  = grant;
    assign p_rd_data = app_rd_data;
    assign next_ptr  = (grant == 3'(NP-1)) ? 3'd0 : grant + 3'd1;

    // A port whose ack is visible this cycle has not yet dropped its request; mask it.
    always_comb begin
        req_eff  = p_req & ~p_req_ack;
        rr_req   = req_eff;
`ifdef SDRC_ARB_FIXED_PRIO_EN
        rr_req[0] = 1'b0;
`endif
        lo_pick  = '0;
        hi_pick  = '0;
        hi_found = 1'b0;
        for (int i = NP - 1; i >= 0; i--) begin
            if (rr_req[i]) begin
                lo_pick = 3'(i);
            end
            if (rr_req[i] && (3'(i) >= rr_ptr)) begin
                hi_pick  = 3'(i);
                hi_found = 1'b1;
            end
        end
        pick = hi_found ? hi_pick : lo_pick;
`ifdef SDRC_ARB_FIXED_PRIO_EN
        if (req_eff[0]) begin
            pick = 3'd0;
        end
`endif
    end

    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        sel_wr_n = 1'b1;
        grant_oh = '0;
        for (int i = 0; i < NP; i++) begin
            if (pick == 3'(i)) begin
                sel_addr = p_req_addr[i*APP_AW +: APP_AW];
                sel_len  = p_req_len[i*bl +: bl];
                sel_wr_n = p_req_wr_n[i];
            end
            grant_oh[i] = (grant == 3'(i));
        end
    end

    // Data-phase steering; everything is quiet outside the owning data state.
    always_comb begin
        app_wr_data = '0;
        app_wr_en_n = '1;
        p_wr_next   = '0;
        p_rd_valid  = '0;
        p_last_rd   = '0;
        if (state == WDATA) begin
            for (int i = 0; i < NP; i++) begin
                if (grant == 3'(i)) begin
                    app_wr_data = p_wr_data[i*dw +: dw];
                    app_wr_en_n = p_wr_en_n[i*(dw/8) +: (dw/8)];
                end
            end
            p_wr_next = grant_oh & {NP{app_wr_next_req}};
        end else if (state == RDATA) begin
            p_rd_valid = grant_oh & {NP{app_rd_valid}};
            p_last_rd  = grant_oh & {NP{app_last_rd}};
        end
    end

    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            grant        <= '0;
            beat_cnt     <= '0;
            app_req      <= 1'b0;
            app_req_addr <= '0;
            app_req_len  <= '0;
            app_req_wr_n <= 1'b1;
            arb_busy     <= 1'b0;
            p_req_ack    <= '0;
        end else begin
            p_req_ack <= '0;
            case (state)
                IDLE: begin
                    if (|req_eff) begin
                        grant        <= pick;
                        app_req      <= 1'b1;
                        app_req_addr <= sel_addr;
                        app_req_len  <= sel_len;
                        app_req_wr_n <= sel_wr_n;
                        arb_busy     <= 1'b1;
                        state        <= REQ;
                    end
                end
                REQ: begin
                    if (app_req_ack) begin
                        app_req   <= 1'b0;
                        p_req_ack <= grant_oh;
                        rr_ptr    <= next_ptr;
                        beat_cnt  <= app_req_len;
                        if (app_req_len == '0) begin
                            state    <= IDLE;
                            arb_busy <= 1'b0;
                        end else if (app_req_wr_n) begin
                            state <= RDATA;
                        end else begin
                            state <= WDATA;
                        end
                    end
                end
                WDATA: begin
                    if (app_wr_next_req) begin
                        beat_cnt <= beat_cnt - bl'(1);
                        if (beat_cnt == bl'(1)) begin
                            state    <= IDLE;
                            arb_busy <= 1'b0;
                        end
                    end
                end
                RDATA: begin
                    if (app_rd_valid && app_last_rd) begin
                        state    <= IDLE;
                        arb_busy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdrc_port_arb.sv
// Directed self-checking bench for sdrc_port_arb with a hand-driven sdrc_core side.
module tb_sdrc_port_arb;

    localparam int NP     = 4;
    localparam int APP_AW = 26;
    localparam int DW     = 32;
    localparam int BL     = 9;

    logic                 sdram_clk = 1'b0;
    logic                 sdram_resetn;
    logic [NP-1:0]        p_req;
    logic [NP*APP_AW-1:0] p_req_addr;
    logic [NP*BL-1:0]     p_req_len;
    logic [NP-1:0]        p_req_wr_n;
    logic [NP-1:0]        p_req_ack;
    logic [NP*DW-1:0]     p_wr_data;
    logic [NP*DW/8-1:0]   p_wr_en_n;
    logic [NP-1:0]        p_wr_next;
    logic [NP-1:0]        p_rd_valid;
    logic [NP-1:0]        p_last_rd;
    logic [DW-1:0]        p_rd_data;
    logic [2:0]           grant_id;
    logic                 arb_busy;
    logic                 app_req;
    logic [APP_AW-1:0]    app_req_addr;
    logic [BL-1:0]        app_req_len;
    logic                 app_req_wr_n;
    logic                 app_req_ack;
    logic [DW-1:0]        app_wr_data;
    logic [DW/8-1:0]      app_wr_en_n;
    logic                 app_wr_next_req;
    logic                 app_rd_valid;
    logic                 app_last_rd;
    logic [DW-1:0]        app_rd_data;

    int n_checks = 0;
    int n_fail   = 0;

    sdrc_port_arb #(
        .NP     (NP),
        .APP_AW (APP_AW),
        .dw     (DW),
        .bl     (BL)
    ) dut (
        .sdram_clk       (sdram_clk),
        .sdram_resetn    (sdram_resetn),
        .p_req           (p_req),
        .p_req_addr      (p_req_addr),
        .p_req_len       (p_req_len),
        .p_req_wr_n      (p_req_wr_n),
        .p_req_ack       (p_req_ack),
        .p_wr_data       (p_wr_data),
        .p_wr_en_n       (p_wr_en_n),
        .p_wr_next       (p_wr_next),
        .p_rd_valid      (p_rd_valid),
        .p_last_rd       (p_last_rd),
        .p_rd_data       (p_rd_data),
        .grant_id        (grant_id),
        .arb_busy        (arb_busy),
        .app_req         (app_req),
        .app_req_addr    (app_req_addr),
        .app_req_len     (app_req_len),
        .app_req_wr_n    (app_req_wr_n),
        .app_req_ack     (app_req_ack),
        .app_wr_data     (app_wr_data),
        .app_wr_en_n     (app_wr_en_n),
        .app_wr_next_req (app_wr_next_req),
        .app_rd_valid    (app_rd_valid),
        .app_last_rd     (app_last_rd),
        .app_rd_data     (app_rd_data)
    );

    always #5 sdram_clk = ~sdram_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sdram_clk);
        #1;
    endtask

    task automatic sample();
        @(negedge sdram_clk);
    endtask

    task automatic set_req(input int port, input logic [APP_AW-1:0] addr, input logic [BL-1:0] len,
                           input logic wr_n, input logic [DW-1:0] data, input logic [3:0] be);
        p_req_addr[port*APP_AW +: APP_AW] = addr;
        p_req_len[port*BL +: BL]          = len;
        p_req_wr_n[port]                  = wr_n;
        p_wr_data[port*DW +: DW]          = data;
        p_wr_en_n[port*4 +: 4]            = be;
        p_req[port]                       = 1'b1;
    endtask

    // Counts edges from the request being raised until app_req is seen.
    task automatic wait_req(output int cycles);
        cycles = 0;
        sample();
        while (!app_req && cycles < 10) begin
            tick();
            sample();
            cycles++;
        end
        check_eq("app_req_seen", 64'(app_req), 64'd1);
    endtask

    task automatic check_grant(input int port, input logic [APP_AW-1:0] addr,
                               input logic [BL-1:0] len, input logic wr_n);
        check_eq("grant_id", 64'(grant_id), 64'(port));
        check_eq("app_req_addr", 64'(app_req_addr), 64'(addr));
        check_eq("app_req_len", 64'(app_req_len), 64'(len));
        check_eq("app_req_wr_n", 64'(app_req_wr_n), 64'(wr_n));
        check_eq("arb_busy_set", 64'(arb_busy), 64'd1);
    endtask

    task automatic do_ack(input int port, input bit drop);
        tick();
        app_req_ack = 1'b1;
        tick();
        app_req_ack = 1'b0;
        if (drop) p_req[port] = 1'b0;
        sample();
        check_eq("p_req_ack", 64'(p_req_ack), 64'd1 << port);
        check_eq("app_req_drop", 64'(app_req), 64'd0);
    endtask

    task automatic wr_beat(input int port, input logic [DW-1:0] data, input logic [3:0] be);
        tick();
        app_wr_next_req = 1'b1;
        sample();
        check_eq("p_wr_next", 64'(p_wr_next), 64'd1 << port);
        check_eq("app_wr_data", 64'(app_wr_data), 64'(data));
        check_eq("app_wr_en_n", 64'(app_wr_en_n), 64'(be));
    endtask

    task automatic rd_beat(input int port, input logic [DW-1:0] data, input bit last);
        tick();
        app_rd_valid = 1'b1;
        app_last_rd  = last;
        app_rd_data  = data;
        sample();
        check_eq("p_rd_valid", 64'(p_rd_valid), 64'd1 << port);
        check_eq("p_last_rd", 64'(p_last_rd), last ? (64'd1 << port) : 64'd0);
        check_eq("p_rd_data", 64'(p_rd_data), 64'(data));
    endtask

    task automatic end_beats();
        tick();
        app_wr_next_req = 1'b0;
        app_rd_valid    = 1'b0;
        app_last_rd     = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_app_req"}, 64'(app_req), 64'd0);
        check_eq({tag, "_addr"}, 64'(app_req_addr), 64'd0);
        check_eq({tag, "_len"}, 64'(app_req_len), 64'd0);
        check_eq({tag, "_wr_n"}, 64'(app_req_wr_n), 64'd1);
        check_eq({tag, "_wr_en_n"}, 64'(app_wr_en_n), 64'hF);
        check_eq({tag, "_ack"}, 64'(p_req_ack), 64'd0);
        check_eq({tag, "_wr_next"}, 64'(p_wr_next), 64'd0);
        check_eq({tag, "_rd_valid"}, 64'(p_rd_valid), 64'd0);
        check_eq({tag, "_grant"}, 64'(grant_id), 64'd0);
        check_eq({tag, "_busy"}, 64'(arb_busy), 64'd0);
    endtask

    initial begin
        int c;
        int exp_port;
        int t2_ports [3] = '{0, 1, 3};

        sdram_resetn    = 1'b0;
        p_req           = '0;
        p_req_addr      = '0;
        p_req_len       = '0;
        p_req_wr_n      = '0;
        p_wr_data       = '0;
        p_wr_en_n       = '1;
        app_req_ack     = 1'b0;
        app_wr_next_req = 1'b0;
        app_rd_valid    = 1'b0;
        app_last_rd     = 1'b0;
        app_rd_data     = '0;

        repeat (3) sample();
        check_reset_outputs("reset");
        tick();
        sdram_resetn = 1'b1;

        // Port 2 read, len 4, addr 0x100.
        tick();
        set_req(2, 26'h100, 9'd4, 1'b1, 32'h0, 4'hF);
        wait_req(c);
        check_eq("t1_latency", 64'(c), 64'd1);
        check_grant(2, 26'h100, 9'd4, 1'b1);
        tick();
        sample();
        check_eq("t1_hold_req", 64'(app_req), 64'd1);
        check_eq("t1_hold_addr", 64'(app_req_addr), 64'h100);
        do_ack(2, 1'b1);
        for (int b = 0; b < 4; b++) rd_beat(2, 32'hA5A5_0000 + 32'(b), b == 3);
        end_beats();
        sample();
        check_eq("t1_busy_fall", 64'(arb_busy), 64'd0);

        // Port 1 zero-length: ack only, requester drops one cycle after seeing the ack.
        tick();
        set_req(1, 26'h200, 9'd0, 1'b0, 32'h0, 4'h0);
        wait_req(c);
        check_grant(1, 26'h200, 9'd0, 1'b0);
        do_ack(1, 1'b0);
        check_eq("t3_busy", 64'(arb_busy), 64'd0);
        tick();
        p_req[1] = 1'b0;
        sample();
        check_eq("t3_no_regrant", 64'(app_req), 64'd0);
        check_eq("t3_ack_pulse", 64'(p_req_ack), 64'd0);

        // Stray core strobes while idle.
        tick();
        app_rd_valid    = 1'b1;
        app_last_rd     = 1'b1;
        app_wr_next_req = 1'b1;
        sample();
        check_eq("t5_rd_valid", 64'(p_rd_valid), 64'd0);
        check_eq("t5_last_rd", 64'(p_last_rd), 64'd0);
        check_eq("t5_wr_next", 64'(p_wr_next), 64'd0);
        end_beats();

        // Reset after 2 of 8 write beats on port 0 (pointer is 2 here, wraps to 0).
        tick();
        set_req(0, 26'h300, 9'd8, 1'b0, 32'hDEAD_BEEF, 4'h0);
        wait_req(c);
        check_grant(0, 26'h300, 9'd8, 1'b0);
        do_ack(0, 1'b1);
        wr_beat(0, 32'hDEAD_BEEF, 4'h0);
        wr_beat(0, 32'hDEAD_BEEF, 4'h0);
        tick();
        sdram_resetn = 1'b0;
        #1;
        check_reset_outputs("t4_rst");
        tick();
        tick();
        sample();
        check_eq("t4_rst_wr_next", 64'(p_wr_next), 64'd0);
        check_eq("t4_rst_ack", 64'(p_req_ack), 64'd0);
        app_wr_next_req = 1'b0;
        tick();
        sdram_resetn = 1'b1;
        set_req(3, 26'h3C0, 9'd1, 1'b1, 32'h0, 4'hF);
        wait_req(c);
        check_eq("t4_fresh_latency", 64'(c), 64'd1);
        check_grant(3, 26'h3C0, 9'd1, 1'b1);
        do_ack(3, 1'b1);
        rd_beat(3, 32'h1234_5678, 1'b1);
        end_beats();
        sample();
        check_eq("t4_fresh_busy", 64'(arb_busy), 64'd0);

        // Ports 0,1,3 request together; pointer wrapped to 0 after port 3.
        tick();
        foreach (t2_ports[k])
            set_req(t2_ports[k], 26'h400 + 26'(t2_ports[k] * 'h100), 9'd1, 1'b0,
                    32'hC0DE_0000 | 32'(t2_ports[k]), 4'(t2_ports[k]));
        foreach (t2_ports[k]) begin
            exp_port = t2_ports[k];
            wait_req(c);
            check_grant(exp_port, 26'h400 + 26'(exp_port * 'h100), 9'd1, 1'b0);
            do_ack(exp_port, 1'b1);
            wr_beat(exp_port, 32'hC0DE_0000 | 32'(exp_port), 4'(exp_port));
            end_beats();
        end

        // Ports 0 and 2 request continuously, 1-word reads.
        tick();
        set_req(0, 26'h10, 9'd1, 1'b1, 32'h0, 4'hF);
        set_req(2, 26'h20, 9'd1, 1'b1, 32'h0, 4'hF);
        for (int i = 0; i < 4; i++) begin
`ifdef SDRC_ARB_FIXED_PRIO_EN
            exp_port = 0;
`else
            exp_port = (i % 2 == 1) ? 2 : 0;
`endif
            wait_req(c);
            check_grant(exp_port, (exp_port == 0) ? 26'h10 : 26'h20, 9'd1, 1'b1);
            do_ack(exp_port, 1'b0);
            rd_beat(exp_port, 32'hBEEF_0000 + 32'(i), 1'b1);
            end_beats();
        end
        p_req = '0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
